// File: rtl/ysyx_23060208_pkg.sv
// Shared definitions for the ysyx_23060208 core: bus response codes,
// memory-mapped peripheral addresses and CLINT responder states.
package ysyx_23060208_pkg;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    localparam logic [31:0] RTC_BASE    = 32'ha000_0048;

    typedef enum logic [1:0] {
        CLINT_IDLE = 2'd0,
        CLINT_WAIT = 2'd1,
        CLINT_RESP = 2'd2
    } clint_state_e;

    typedef enum logic [1:0] {
        DEC_LO  = 2'd0,
        DEC_HI  = 2'd1,
        DEC_ERR = 2'd2
    } rtc_decode_e;

endpackage

// File: rtl/ysyx_23060208_mtime.sv
// Free-running 64-bit machine timer with a TICK_DIV-cycle prescaler.
module ysyx_23060208_mtime #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [63:0] mtime
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre_q;
    logic [63:0]   mtime_q;
    logic          tick;

    // With TICK_DIV == 1 the prescaler is pinned at zero and ticks every cycle.
    assign tick = (pre_q == PRE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q   <= '0;
            mtime_q <= '0;
        end else begin
            pre_q <= tick ? '0 : pre_q + 1'b1;
            if (tick) begin
                mtime_q <= mtime_q + 64'd1;
            end
        end
    end

    assign mtime = mtime_q;

endmodule

// File: rtl/ysyx_23060208_clint.sv
// Read-only AXI4-Lite responder exposing the 64-bit RTC; a low-word read
// snapshots the high word so low-then-high reads are coherent.
module ysyx_23060208_clint
    import ysyx_23060208_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(RTC_BASE),
    parameter int unsigned           TICK_DIV   = 1,
    parameter int unsigned           RESP_DELAY = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rvalid,
    input  logic                  rready
);

    localparam logic [ADDR_WIDTH-1:0] HI_ADDR = BASE_ADDR + ADDR_WIDTH'(4);
    localparam int unsigned           DW      = (RESP_DELAY > 1) ? $clog2(RESP_DELAY) : 1;
    localparam logic [DW-1:0]         DLY_LOAD = (RESP_DELAY > 0) ? DW'(RESP_DELAY - 1) : '0;

    clint_state_e          state_q, state_d;
    rtc_decode_e           dec;
    logic [63:0]           mtime;
    logic [31:0]           hi_shadow_q, hi_shadow_d;
    logic [DW-1:0]         dly_q, dly_d;
    logic                  arready_d, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_d;
    logic [1:0]            rresp_d;

    ysyx_23060208_mtime #(
        .TICK_DIV (TICK_DIV)
    ) u_mtime (
        .clk   (clk),
        .rst_n (rst_n),
        .mtime (mtime)
    );

    always_comb begin
        dec = DEC_ERR;
        if (araddr == BASE_ADDR) begin
            dec = DEC_LO;
        end else if (araddr == HI_ADDR) begin
            dec = DEC_HI;
        end
    end

    // Outputs are registered, so the next-state process also computes their
    // next values; arready is held off in reset and rises on the first edge.
    always_comb begin
        state_d     = state_q;
        arready_d   = arready;
        rvalid_d    = rvalid;
        rdata_d     = rdata;
        rresp_d     = rresp;
        dly_d       = dly_q;
        hi_shadow_d = hi_shadow_q;

        case (state_q)
            CLINT_IDLE: begin
                arready_d = 1'b1;
                if (arvalid && arready) begin
                    arready_d = 1'b0;
                    case (dec)
                        DEC_LO: begin
                            rdata_d     = DATA_WIDTH'(mtime[31:0]);
                            rresp_d     = RESP_OKAY;
                            hi_shadow_d = mtime[63:32];
                        end
                        DEC_HI: begin
                            rdata_d = DATA_WIDTH'(hi_shadow_q);
                            rresp_d = RESP_OKAY;
                        end
                        default: begin
                            rdata_d = '0;
                            rresp_d = RESP_SLVERR;
                        end
                    endcase
                    if (RESP_DELAY > 0) begin
                        state_d = CLINT_WAIT;
                        dly_d   = DLY_LOAD;
                    end else begin
                        state_d  = CLINT_RESP;
                        rvalid_d = 1'b1;
                    end
                end
            end
            CLINT_WAIT: begin
                arready_d = 1'b0;
                if (dly_q == '0) begin
                    state_d  = CLINT_RESP;
                    rvalid_d = 1'b1;
                end else begin
                    dly_d = dly_q - 1'b1;
                end
            end
            CLINT_RESP: begin
                arready_d = 1'b0;
                if (rready) begin
                    state_d   = CLINT_IDLE;
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                end
            end
            default: begin
                state_d   = CLINT_IDLE;
                arready_d = 1'b0;
                rvalid_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CLINT_IDLE;
            arready     <= 1'b0;
            rvalid      <= 1'b0;
            rdata       <= '0;
            rresp       <= RESP_OKAY;
            dly_q       <= '0;
            hi_shadow_q <= '0;
        end else begin
            state_q     <= state_d;
            arready     <= arready_d;
            rvalid      <= rvalid_d;
            rdata       <= rdata_d;
            rresp       <= rresp_d;
            dly_q       <= dly_d;
            hi_shadow_q <= hi_shadow_d;
        end
    end

endmodule

// File: tb/tb_ysyx_23060208_clint.sv
// Bench for ysyx_23060208_clint: two instances (fast tick / delayed response)
// checked against an arithmetic model of mtime and the high-word snapshot.
module tb_ysyx_23060208_clint;

    localparam logic [31:0] BASE  = 32'ha000_0048;
    localparam int unsigned DIV_A = 1;
    localparam int unsigned DLY_A = 0;
    localparam int unsigned DIV_B = 4;
    localparam int unsigned DLY_B = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] araddr  [2];
    logic        arvalid [2];
    logic        arready [2];
    logic [31:0] rdata   [2];
    logic [1:0]  rresp   [2];
    logic        rvalid  [2];
    logic        rready  [2];

    int checks = 0;
    int errors = 0;

    longint unsigned edges;
    logic [63:0]     m_base [2];
    longint unsigned m_ref  [2];
    longint unsigned m_ph   [2];
    logic [31:0]     m_shadow [2];

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    ysyx_23060208_clint #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .BASE_ADDR  (BASE),
        .TICK_DIV   (DIV_A),
        .RESP_DELAY (DLY_A)
    ) dut_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .araddr  (araddr[0]),
        .arvalid (arvalid[0]),
        .arready (arready[0]),
        .rdata   (rdata[0]),
        .rresp   (rresp[0]),
        .rvalid  (rvalid[0]),
        .rready  (rready[0])
    );

    ysyx_23060208_clint #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .BASE_ADDR  (BASE),
        .TICK_DIV   (DIV_B),
        .RESP_DELAY (DLY_B)
    ) dut_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .araddr  (araddr[1]),
        .arvalid (arvalid[1]),
        .arready (arready[1]),
        .rdata   (rdata[1]),
        .rresp   (rresp[1]),
        .rvalid  (rvalid[1]),
        .rready  (rready[1])
    );

    function automatic longint unsigned div_of(input int d);
        return (d == 0) ? longint'(DIV_A) : longint'(DIV_B);
    endfunction

    function automatic longint unsigned dly_of(input int d);
        return (d == 0) ? longint'(DLY_A) : longint'(DLY_B);
    endfunction

    // mtime after n clock edges since reset: base value plus whole ticks elapsed.
    function automatic logic [63:0] model_mtime(input int d, input longint unsigned n);
        return m_base[d] + 64'((n - m_ref[d] + m_ph[d]) / div_of(d));
    endfunction

    function automatic longint unsigned model_phase(input int d);
        return (edges - m_ref[d] + m_ph[d]) % div_of(d);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_base[i]   = '0;
            m_ref[i]    = 0;
            m_ph[i]     = 0;
            m_shadow[i] = '0;
        end
    endtask

    task automatic model_rebase(input int d, input logic [63:0] v);
        m_ph[d]   = model_phase(d);
        m_ref[d]  = edges;
        m_base[d] = v;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input int d);
        check("rst_arready", 64'(arready[d]), 64'd0);
        check("rst_rvalid",  64'(rvalid[d]),  64'd0);
        check("rst_rdata",   64'(rdata[d]),   64'd0);
        check("rst_rresp",   64'(rresp[d]),   64'd0);
    endtask

    // Full read transaction; caller is positioned at a falling edge.
    task automatic do_read(input int d, input logic [31:0] addr, input int hold,
                           output logic [31:0] data, output logic [1:0] resp);
        longint unsigned hs;
        logic [63:0]     snap;
        logic [31:0]     exp_data;
        logic [1:0]      exp_resp;
        int              t;
        araddr[d]  = addr;
        arvalid[d] = 1'b1;
        rready[d]  = (hold == 0);
        t = 0;
        while (arready[d] !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("ar_wait_bound", 64'(t < 20), 64'd1);
        hs = edges + 1;
        @(posedge clk);
        #1;
        arvalid[d] = 1'b0;
        araddr[d]  = $urandom;
        snap = model_mtime(d, hs - 1);
        if (addr == BASE) begin
            exp_data    = snap[31:0];
            exp_resp    = 2'b00;
            m_shadow[d] = snap[63:32];
        end else if (addr == BASE + 32'd4) begin
            exp_data = m_shadow[d];
            exp_resp = 2'b00;
        end else begin
            exp_data = '0;
            exp_resp = 2'b10;
        end
        @(negedge clk);
        check("arready_low_after_ar", 64'(arready[d]), 64'd0);
        t = 0;
        while (rvalid[d] !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("rvalid_latency", 64'(edges - hs), 64'(dly_of(d)));
        check("rdata", 64'(rdata[d]), 64'(exp_data));
        check("rresp", 64'(rresp[d]), 64'(exp_resp));
        data = rdata[d];
        resp = rresp[d];
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_rvalid",  64'(rvalid[d]),  64'd1);
            check("hold_arready", 64'(arready[d]), 64'd0);
            check("hold_rdata",   64'(rdata[d]),   64'(exp_data));
        end
        rready[d] = 1'b1;
        @(negedge clk);
        check("r_done_rvalid",  64'(rvalid[d]),  64'd0);
        check("r_done_arready", 64'(arready[d]), 64'd1);
        rready[d] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0]     data;
        logic [1:0]      resp;
        longint unsigned e;
        int              t;
        int              d;
        int              sel;
        logic [31:0]     addr;

        for (int i = 0; i < 2; i++) begin
            araddr[i]  = BASE;
            arvalid[i] = 1'b0;
            rready[i]  = 1'b0;
        end
        model_reset();

        // Reset values and arready rising on the first edge after release.
        repeat (3) @(negedge clk);
        check_reset_outputs(0);
        check_reset_outputs(1);
        rst_n = 1'b1;
        check("arready_before_edge", 64'(arready[0]), 64'd0);
        @(negedge clk);
        check("arready_first_edge_a", 64'(arready[0]), 64'd1);
        check("arready_first_edge_b", 64'(arready[1]), 64'd1);

        // TICK_DIV=1: handshake on edge 2 sees mtime after one tick.
        do_read(0, BASE, 0, data, resp);
        check("first_low_a", 64'(data), 64'd1);
        do_read(0, BASE, 0, data, resp);
        do_read(0, BASE + 32'd4, 0, data, resp);
        check("hi_after_reset", 64'(data), 64'd0);

        // TICK_DIV=4: handshake after 40 edges reads 10.
        while (edges < 40) @(negedge clk);
        do_read(1, BASE, 0, data, resp);
        check("div4_40_cycles", 64'(data), 64'd10);

        // Low/high pair across a low-word carry.
        @(negedge clk);
        force dut_a.u_mtime.mtime_q = 64'h0000_0001_FFFF_FFFF;
        release dut_a.u_mtime.mtime_q;
        model_rebase(0, 64'h0000_0001_FFFF_FFFF);
        do_read(0, BASE, 0, data, resp);
        check("pair_low", 64'(data), 64'hFFFF_FFFF);
        do_read(0, BASE + 32'd4, 0, data, resp);
        check("pair_high_snapshot", 64'(data), 64'h1);
        do_read(0, BASE, 0, data, resp);
        do_read(0, BASE + 32'd4, 0, data, resp);
        check("live_high_carried", 64'(data), 64'h2);

        // Bad address: zero data, SLVERR, counter unaffected.
        do_read(0, 32'ha000_0050, 0, data, resp);
        check("bad_rdata", 64'(data), 64'd0);
        check("bad_rresp", 64'(resp), 64'd2);
        do_read(0, BASE, 1, data, resp);

        // Backpressure with RESP_DELAY=3.
        do_read(1, BASE, 10, data, resp);

        // TICK_DIV=4 wrap from all-ones, forced on a prescaler boundary.
        @(negedge clk);
        while (model_phase(1) != 0) @(negedge clk);
        force dut_b.u_mtime.mtime_q = 64'hFFFF_FFFF_FFFF_FFFF;
        release dut_b.u_mtime.mtime_q;
        model_rebase(1, 64'hFFFF_FFFF_FFFF_FFFF);
        e = edges;
        while (edges < e + 4) @(negedge clk);
        do_read(1, BASE, 0, data, resp);
        check("wrap_low", 64'(data), 64'd0);
        do_read(1, BASE + 32'd4, 0, data, resp);
        check("wrap_high", 64'(data), 64'd0);

        // Reset asserted while dut_b holds a response.
        @(negedge clk);
        araddr[1]  = BASE;
        arvalid[1] = 1'b1;
        rready[1]  = 1'b0;
        t = 0;
        while (arready[1] !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        arvalid[1] = 1'b0;
        t = 0;
        while (rvalid[1] !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("resp_reached", 64'(rvalid[1]), 64'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs(1);
        check_reset_outputs(0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_read(1, BASE, 0, data, resp);
        check("post_reset_small", 64'(data < 32'd16), 64'd1);
        do_read(1, BASE + 32'd4, 0, data, resp);
        check("post_reset_shadow", 64'(data), 64'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 40; n++) begin
            d   = int'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 3));
            case (sel)
                0:       addr = BASE;
                1:       addr = BASE + 32'd4;
                2:       addr = BASE + 32'd8;
                default: addr = $urandom;
            endcase
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_read(d, addr, int'($urandom_range(0, 3)), data, resp);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
